// File: rtl/regfile_pkg.sv
// Shared types for the regfile write-back path: default widths, queued entry
// layout and the producer identifiers used by the round-robin arbiter.
package regfile_pkg;

  localparam int RF_DATA_WIDTH    = 16;
  localparam int RF_REGADDR_WIDTH = 3;

  typedef struct packed {
    logic [RF_REGADDR_WIDTH-1:0] rd;
    logic [RF_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue. Every slot and its valid bit are exposed so the
// owner can build the pending vector and search for forwarding matches.
module wb_fifo import regfile_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             empty_o,
  output logic             full_o
);

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               do_push, do_pop;

  assign empty_o = ~|valid_q;
  assign full_o  = &valid_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Valid slots stay contiguous from rd_ptr, so a per-slot bit doubles as the count.
  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
    if (do_push) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-side controller: round-robin ALU/MEM intake, write-back queue,
// debug-priority write port, pending vector. Forwarding under REGFILE_WB_BYPASS_EN.
module regfile_wb_ctrl import regfile_pkg::*; #(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int REGADDR_WIDTH = RF_REGADDR_WIDTH,
  parameter int NUM_REGS      = 1 << REGADDR_WIDTH,
  parameter int WB_DEPTH      = 4,
  parameter bit ZERO_REG      = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [REGADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  input  logic                     dbg_we,
  input  logic [REGADDR_WIDTH-1:0] dbg_reg,
  input  logic [DATA_WIDTH-1:0]    dbg_data,
  output logic                     rf_reg_write,
  output logic [REGADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic [NUM_REGS-1:0]      pending,
  input  logic [REGADDR_WIDTH-1:0] rs1,
  input  logic [REGADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0]    rf_rd1,
  input  logic [DATA_WIDTH-1:0]    rf_rd2,
  output logic [DATA_WIDTH-1:0]    fwd_rd1,
  output logic [DATA_WIDTH-1:0]    fwd_rd2,
  output logic                     empty,
  output logic                     full
);

  typedef struct packed {
    logic [REGADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  localparam int PTR_W = $clog2(WB_DEPTH);

  src_e                rr_q;
  logic                alu_grant, mem_grant, push, pop;
  entry_t              in_entry, head;
  entry_t              entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] slot_valid;
  logic [PTR_W-1:0]    rd_ptr;

  // Ready depends only on registered state and valids; a same-cycle pop never frees a slot.
  assign alu_grant = alu_valid & (~mem_valid | (rr_q == SRC_ALU));
  assign mem_grant = mem_valid & (~alu_valid | (rr_q == SRC_MEM));
  assign alu_ready = alu_grant & ~full & ~reset;
  assign mem_ready = mem_grant & ~full & ~reset;

  always_comb begin
    in_entry.rd   = alu_ready ? alu_rd   : mem_rd;
    in_entry.data = alu_ready ? alu_data : mem_data;
  end

  assign push = (alu_ready | mem_ready) & ~(ZERO_REG && (in_entry.rd == '0));
  assign pop  = ~dbg_we & ~empty & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rr_q <= SRC_ALU;
    else if (alu_ready) rr_q <= SRC_MEM;
    else if (mem_ready) rr_q <= SRC_ALU;
  end

  wb_fifo #(
    .DEPTH   (WB_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (in_entry),
    .pop_i        (pop),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (slot_valid),
    .rd_ptr_o     (rd_ptr),
    .empty_o      (empty),
    .full_o       (full)
  );

  always_comb begin
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    if (!reset) begin
      if (dbg_we) begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = dbg_reg;
        rf_write_data = dbg_data;
      end else if (!empty) begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = head.rd;
        rf_write_data = head.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (slot_valid[i]) pending[entries[i].rd] = 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  function automatic logic [PTR_W-1:0] age_slot(input logic [PTR_W-1:0] base, input int k);
    return base + PTR_W'(k);
  endfunction

  // Walk oldest to youngest so the youngest match wins; debug data overrides the queue.
  always_comb begin
    fwd_rd1 = rf_rd1;
    fwd_rd2 = rf_rd2;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (slot_valid[age_slot(rd_ptr, k)]) begin
        if (entries[age_slot(rd_ptr, k)].rd == rs1) fwd_rd1 = entries[age_slot(rd_ptr, k)].data;
        if (entries[age_slot(rd_ptr, k)].rd == rs2) fwd_rd2 = entries[age_slot(rd_ptr, k)].data;
      end
    end
    if (dbg_we && dbg_reg == rs1) fwd_rd1 = dbg_data;
    if (dbg_we && dbg_reg == rs2) fwd_rd2 = dbg_data;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rs1, rs2, rd_ptr};
  assign fwd_rd1 = rf_rd1;
  assign fwd_rd2 = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl (ZERO_REG=1): a scoreboard queue holds
// every accepted non-r0 result and is popped as queued writes reach the regfile.
module tb_regfile_wb_ctrl;

  localparam int DW  = 16;
  localparam int RAW = 3;
  localparam int NR  = 8;

  typedef struct packed {
    logic [RAW-1:0] rd;
    logic [DW-1:0]  data;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           alu_valid = 1'b0, mem_valid = 1'b0, dbg_we = 1'b0;
  logic [RAW-1:0] alu_rd = '0, mem_rd = '0, dbg_reg = '0, rs1 = 3'd2, rs2 = 3'd5;
  logic [DW-1:0]  alu_data = '0, mem_data = '0, dbg_data = '0;
  logic [DW-1:0]  rf_rd1 = 16'h0F0F, rf_rd2 = 16'h7070;
  logic           alu_ready, mem_ready, rf_reg_write, empty, full;
  logic [RAW-1:0] rf_write_reg;
  logic [DW-1:0]  rf_write_data, fwd_rd1, fwd_rd2;
  logic [NR-1:0]  pending;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic a_acc, m_acc;

  regfile_wb_ctrl #(.DATA_WIDTH(DW), .REGADDR_WIDTH(RAW), .NUM_REGS(NR),
                    .WB_DEPTH(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .pending(pending), .rs1(rs1), .rs2(rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the negedge and score whatever the write port presents this cycle.
  task automatic mon();
    exp_t e;
    @(negedge clk);
    if (rf_reg_write === 1'b1) begin
      $display("t=%0t rf write r%0d = 0x%04h%s", $time, rf_write_reg, rf_write_data,
               dbg_we ? " (dbg)" : "");
      if (dbg_we) begin
        check("dbg_write_reg", rf_write_reg, dbg_reg);
        check("dbg_write_data", rf_write_data, dbg_data);
      end else if (sb_q.size() == 0) begin
        check("unexpected_write", rf_reg_write, 0);
      end else begin
        e = sb_q.pop_front();
        check("wb_reg", rf_write_reg, e.rd);
        check("wb_data", rf_write_data, e.data);
      end
    end
  endtask

  // Record handshakes seen at the negedge, then step to just past the next posedge.
  task automatic adv();
    a_acc = alu_valid & (alu_ready === 1'b1);
    m_acc = mem_valid & (mem_ready === 1'b1);
    if (a_acc && alu_rd != 0) sb_q.push_back({alu_rd, alu_data});
    if (m_acc && mem_rd != 0) sb_q.push_back({mem_rd, mem_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with both producers already requesting.
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA001;
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'hB005;
    mon();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rf_we", rf_reg_write, 0);
    check("rst_rf_reg", rf_write_reg, 0);
    check("rst_rf_data", rf_write_data, 0);
    check("rst_pending", pending, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    adv();
    reset = 1'b0;

    // Both valid: ALU granted first, then strict alternation.
    begin
      int an = 1, mn = 5;
      for (int k = 0; k < 4; k++) begin
        alu_rd = RAW'(an); alu_data = 16'hA000 | DW'(an);
        mem_rd = RAW'(mn); mem_data = 16'hB000 | DW'(mn);
        mon();
        check("rr_both_ready", alu_ready & mem_ready, 0);
        check("rr_alu_grant", alu_ready, (k % 2) == 0);
        check("rr_mem_grant", mem_ready, (k % 2) == 1);
        adv();
        if (a_acc) an++;
        if (m_acc) mn++;
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin mon(); adv(); end
    mon(); check("rr_drained_empty", empty, 1); adv();

    // Single ALU result appears on the write port the following cycle.
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
    mon(); check("lat_alu_ready", alu_ready, 1); adv();
    alu_valid = 1'b0;
    mon();
    check("lat_rf_we", rf_reg_write, 1);
    check("lat_rf_reg", rf_write_reg, 3);
    check("lat_rf_data", rf_write_data, 16'h1234);
    adv();
    mon(); check("lat_empty", empty, 1); adv();

    // Debug holds the port while the queue fills; pending excludes debug writes.
    dbg_we = 1'b1; dbg_reg = 3'd7; alu_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      alu_rd = (k < 4) ? RAW'(k + 1) : 3'd5;
      alu_data = 16'hC000 | DW'(alu_rd);
      dbg_data = 16'hD000 + DW'(k);
      mon();
      check("dbg_alu_ready", alu_ready, k < 4);
      if (k >= 4) begin
        check("dbg_full", full, 1);
        check("dbg_pending", pending, 8'h1E);
      end
      adv();
    end
    dbg_we = 1'b0;
    mon();
    check("full_pop_ready", alu_ready, 0);
    check("full_pop_full", full, 1);
    adv();
    mon(); check("after_pop_ready", alu_ready, 1); adv();
    alu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin mon(); adv(); end
    mon(); check("dbg_drained_empty", empty, 1); adv();

    // Register 0 result is acknowledged but never queued.
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h5555;
    mon(); check("zr_alu_ready", alu_ready, 1); adv();
    alu_valid = 1'b0;
    mon();
    check("zr_rf_we", rf_reg_write, 0);
    check("zr_pending", pending, 0);
    check("zr_empty", empty, 1);
    adv();

    // Forwarding: youngest same-rd entry, debug in flight takes precedence.
    dbg_we = 1'b1; dbg_reg = 3'd7; dbg_data = 16'hD100;
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'hAAAA;
    mon(); adv();
    alu_data = 16'hBBBB;
    mon(); adv();
    alu_valid = 1'b0;
    mon();
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_fwd1_young", fwd_rd1, 16'hBBBB);
`else
    check("byp_fwd1_off", fwd_rd1, 16'h0F0F);
`endif
    check("byp_fwd2_miss", fwd_rd2, 16'h7070);
    check("byp_pending", pending, 8'h04);
    adv();
    dbg_reg = 3'd2; dbg_data = 16'hCCCC;
    mon();
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_fwd1_dbg", fwd_rd1, 16'hCCCC);
`else
    check("byp_fwd1_dbg_off", fwd_rd1, 16'h0F0F);
`endif
    adv();
    dbg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin mon(); adv(); end

    // Reset with three entries queued discards them without a write.
    dbg_we = 1'b1; dbg_reg = 3'd7; dbg_data = 16'hD200; alu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_rd = RAW'(k + 4); alu_data = 16'hE000 | DW'(k);
      mon(); adv();
    end
    mon(); check("mid_pending_before", pending, 8'h70); adv();
    alu_valid = 1'b0; dbg_we = 1'b0;
    reset = 1'b1;
    sb_q.delete();
    mon();
    check("mid_rst_empty", empty, 1);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_rf_we", rf_reg_write, 0);
    adv();
    reset = 1'b0;
    mon();
    check("post_rst_empty", empty, 1);
    check("post_rst_rf_we", rf_reg_write, 0);
    adv();

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
